mult16_seq_ctrl: RTL
====================

Name: mult16_seq_ctrl

Overview:
- Sequencing controller that computes an unsigned 16x16 -> 32-bit product by time-multiplexing one external 8x8 multiplier hard block (mult_8) over four partial products.
- Sits between a fabric-side valid/ready requester and the mult_8 instance.
- Drives the multiplier operands, collects its results after a fixed pipeline latency, and accumulates them with the correct shifts.

Parameters:
- MULT_LAT, 1: register stages between m_a/m_b and m_y in the external multiplier (legal 0..3).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request operands valid
- in_ready  output  1  controller can accept a request
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  32  product a*b
- busy  output  1  high whenever state != IDLE
- m_sign  output  1  sign control to mult_8; constant 0
- m_a  output  8  multiplier operand A
- m_b  output  8  multiplier operand B
- m_y  input  16  multiplier product, valid MULT_LAT cycles after the operands

Behaviour:
- The reset is synchronous and active-high; this block has one clock. Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, busy=0, m_a=0, m_b=0, accumulator=0, issue/collect counters=0, in-flight tracking cleared.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - An accept edge occurs when in_valid & in_ready at an edge (edge T).
  - On accept: latch a and b, clear the accumulator, go to ISSUE.
- ISSUE:
  - Lasts exactly 4 cycles (T+1..T+4), issuing one pair per cycle in this order:
    - k=0: a[7:0] x b[7:0], shift 0
    - k=1: a[7:0] x b[15:8], shift 8
    - k=2: a[15:8] x b[7:0], shift 8
    - k=3: a[15:8] x b[15:8], shift 16
  - m_a/m_b are combinational from state and the latched operands.
  - When no issue is active, m_a=m_b=0.
- Collection:
  - The product for issue k is sampled from m_y at the end of cycle T+1+k+MULT_LAT.
  - Accumulate: acc <= acc + (m_y << shift_k), 32-bit, no overflow possible.
  - A shift register of depth MULT_LAT carries the shift tag alongside each issue.
- DRAIN: entered after issue 3; waits until collection k=3 completes. When MULT_LAT=0, DRAIN is skipped and ISSUE goes directly to DONE.
- DONE:
  - out_valid=1 and y=acc, starting cycle T+5+MULT_LAT.
  - Latency is 5+MULT_LAT cycles from the accept edge.
  - y and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0 and go to IDLE. in_ready rises the next cycle.
- Throughput: one result per 6+MULT_LAT cycles when back-to-back with out_ready=1.
- in_ready=0 in every state except IDLE. in_valid and operand changes outside IDLE are ignored.
- Reset asserted mid-operation:
  - All state returns to reset values at that edge.
  - In-flight m_y returns arriving afterwards are discarded and must not corrupt the next accumulation.
- y is 0 outside DONE; it is not required to retain the previous result.
- m_sign is tied 0; signed operation is out of scope.

Test Plan:
- Bench models the multiplier as m_y = m_a*m_b delayed MULT_LAT cycles. Run all scenarios at MULT_LAT=0, 1 and 3.
- a=0x1234, b=0x5678, out_ready=1 -> y=0x06260060, out_valid exactly 5+MULT_LAT cycles after the accept edge, held one cycle; m_a/m_b sequence 34/78, 34/56, 12/78, 12/56.
- a=0xFFFF, b=0xFFFF, then a=0x0000, b=0xBEEF, then a=0x0001, b=0x8000 -> y=0xFFFE0001, 0x00000000, 0x00008000.
- Backpressure: a=0x00FF, b=0x0100, out_ready=0 for 10 cycles after out_valid rises -> y=0x0000FF00 and out_valid stable the whole time; in_ready=0 and in_valid pulses are ignored; single handshake when out_ready=1.
- Back-to-back: 20 random pairs with in_valid held high and out_ready=1 -> every y matches the reference model; accept spacing is exactly 6+MULT_LAT cycles.
- Reset mid-op: accept a=0xABCD, b=0x1234; assert reset at T+3 for 1 cycle; then request a=0x0003, b=0x0005 -> all outputs reach reset values at the reset edge; next result y=0x0000000F with no stale partial products.
- Idle check: no request for 50 cycles -> m_a=m_b=0, m_sign=0, busy=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/mult16_seq_ctrl.sv
// Unsigned 16x16 -> 32 multiply sequenced over one external 8x8 multiplier.
// Four partial products are issued back to back and accumulated MULT_LAT cycles later.
module mult16_seq_ctrl #(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy,
  output logic        m_sign,
  output logic [7:0]  m_a,
  output logic [7:0]  m_b,
  input  logic [15:0] m_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, b_reg;
  logic [31:0] acc_reg;
  logic [1:0]  issue_cnt_reg;

  logic        iss_valid;
  logic [1:0]  iss_k;
  logic        col_valid;
  logic [1:0]  col_k;
  logic [4:0]  col_shift;
  logic [31:0] col_term;

  assign iss_valid = (state_reg == ISSUE);
  assign iss_k     = issue_cnt_reg;

  // The partial-product index travels with each issue so the returning m_y
  // is shifted correctly; reset empties the pipe so stale returns are dropped.
  generate
    if (MULT_LAT == 0) begin : g_nopipe
      assign col_valid = iss_valid;
      assign col_k     = iss_k;
    end else begin : g_pipe
      logic       vld_reg [MULT_LAT];
      logic [1:0] k_reg   [MULT_LAT];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MULT_LAT; i++) begin
            vld_reg[i] <= 1'b0;
            k_reg[i]   <= 2'd0;
          end
        end else begin
          vld_reg[0] <= iss_valid;
          k_reg[0]   <= iss_k;
          for (int i = 1; i < MULT_LAT; i++) begin
            vld_reg[i] <= vld_reg[i-1];
            k_reg[i]   <= k_reg[i-1];
          end
        end
      end

      assign col_valid = vld_reg[MULT_LAT-1];
      assign col_k     = k_reg[MULT_LAT-1];
    end
  endgenerate

  always_comb begin
    col_shift = 5'd0;
    case (col_k)
      2'd0:    col_shift = 5'd0;
      2'd1:    col_shift = 5'd8;
      2'd2:    col_shift = 5'd8;
      default: col_shift = 5'd16;
    endcase
  end

  assign col_term = {16'h0000, m_y} << col_shift;

  // k bit1 selects the high byte of a, bit0 the high byte of b.
  assign m_a    = iss_valid ? (iss_k[1] ? a_reg[15:8] : a_reg[7:0]) : 8'h00;
  assign m_b    = iss_valid ? (iss_k[0] ? b_reg[15:8] : b_reg[7:0]) : 8'h00;
  assign m_sign = 1'b0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (in_valid) state_next = ISSUE;
      ISSUE: begin
        if (issue_cnt_reg == 2'd3) begin
          // With no multiplier latency the last product lands this cycle.
          if (col_valid && col_k == 2'd3) state_next = DONE;
          else                             state_next = DRAIN;
        end
      end
      DRAIN: if (col_valid && col_k == 2'd3) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_reg         <= 16'h0000;
      b_reg         <= 16'h0000;
      acc_reg       <= 32'h0000_0000;
      issue_cnt_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        a_reg         <= a;
        b_reg         <= b;
        acc_reg       <= 32'h0000_0000;
        issue_cnt_reg <= 2'd0;
      end else begin
        if (col_valid) acc_reg <= acc_reg + col_term;
        if (state_reg == ISSUE) issue_cnt_reg <= issue_cnt_reg + 2'd1;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign y         = (state_reg == DONE) ? acc_reg : 32'h0000_0000;

endmodule
